memory_dump_reader: RTL and testbench

- Read sequencer placed directly in front of the 256x16 single-port read-only block-RAM memory; drives its addr/cs/byte_sel and captures its 8-bit byte output.
- On a start pulse, walks an address range and splits each 16-bit word into two bytes.
- Emits the bytes on a valid/ready byte stream, e.g. to the UART dump path of the memory test.
- Signals busy for the run and pulses done at the end.

---
 rtl/memory_dump_reader.sv | 141 ++++++++++++++
 tb/tb_memory_dump_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dump_reader.sv
// Memory dump sequencer: walks a word range of a 1-cycle-latency byte-lane RAM and streams each word as two bytes.
// Latency: first byte valid 4 cycles after an accepted start; 5 cycles per word with out_ready held high.
// Backpressure: out_valid/out_data held until out_ready, RAM deselected while stalled; MEMORY_DUMP_CHECKSUM_EN appends a mod-256 sum byte.
module memory_dump_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_byte_sel,
    input  logic [7:0]            mem_data,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

`ifdef MEMORY_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, ISSUE, CAP1, CAP2, EMIT0, EMIT1, FINISH, CHK} state_t;
    localparam state_t AFTER_DATA = CHK;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, CAP1, CAP2, EMIT0, EMIT1, FINISH} state_t;
    localparam state_t AFTER_DATA = FINISH;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur, last;
    logic [7:0]            b0, b1;
    logic                  xfer;
    logic                  at_last;

    assign xfer     = out_valid & out_ready;
    assign at_last  = (cur == last);
    // The address stays on cur through CAP1/CAP2 so the repeated RAM reads return the same word.
    assign mem_addr = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAP1;
            CAP1:    state_nxt = CAP2;
            CAP2:    state_nxt = EMIT0;
            EMIT0:   if (xfer) state_nxt = EMIT1;
            EMIT1:   if (xfer) state_nxt = at_last ? AFTER_DATA : ISSUE;
`ifdef MEMORY_DUMP_CHECKSUM_EN
            CHK:     if (xfer) state_nxt = FINISH;
`endif
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= '0;
            last <= '0;
            b0   <= 8'h00;
            b1   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur  <= start_addr;
                        last <= end_addr;
                    end
                end
                CAP1:    b0 <= mem_data;
                CAP2:    b1 <= mem_data;
                EMIT1:   if (xfer && !at_last) cur <= cur + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

`ifdef MEMORY_DUMP_CHECKSUM_EN
    logic [7:0] acc;

    // Only data bytes are summed; the checksum byte itself is never added.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= 8'h00;
        end else if (state == IDLE && start) begin
            acc <= 8'h00;
        end else if (xfer && (state == EMIT0 || state == EMIT1)) begin
            acc <= acc + out_data;
        end
    end
`endif

    always_comb begin
        mem_cs       = 1'b0;
        mem_byte_sel = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            ISSUE: mem_cs = 1'b1;
            CAP1: begin
                mem_cs       = 1'b1;
                mem_byte_sel = HIGH_FIRST;
            end
            CAP2: begin
                mem_cs       = 1'b1;
                mem_byte_sel = ~HIGH_FIRST;
            end
            EMIT0: begin
                out_valid = 1'b1;
                out_data  = b0;
            end
            EMIT1: begin
                out_valid = 1'b1;
                out_data  = b1;
            end
`ifdef MEMORY_DUMP_CHECKSUM_EN
            CHK: begin
                out_valid = 1'b1;
                out_data  = acc;
            end
`endif
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_dump_reader.sv
// Bench for memory_dump_reader: two instances (low-first, high-first) on behavioural 256x16 RAMs,
// scoreboard queues of expected addresses/bytes drained by a single negedge monitor.
module tb_memory_dump_reader;

`ifdef MEMORY_DUMP_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_addr, end_addr;
    logic       out_ready, rdy_man, rdy_rand, rdy_mode;
    logic       sel;

    logic [7:0] mem_addr  [2];
    logic [7:0] mem_data  [2];
    logic [7:0] out_data  [2];
    logic [1:0] mem_cs, mem_byte_sel, out_valid, busy, done;

    logic [15:0] mem   [256];
    logic [15:0] ram_q [2];

    exp_t       exp_q  [$];
    logic [7:0] addr_q [$];
    logic [7:0] ck = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign out_ready = rdy_mode ? rdy_rand : rdy_man;
    always @(posedge clk) rdy_rand <= 1'($urandom_range(0, 1));

    memory_dump_reader #(.ADDR_WIDTH(8), .HIGH_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .mem_addr(mem_addr[0]), .mem_cs(mem_cs[0]), .mem_byte_sel(mem_byte_sel[0]), .mem_data(mem_data[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .busy(busy[0]), .done(done[0]));

    memory_dump_reader #(.ADDR_WIDTH(8), .HIGH_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .mem_addr(mem_addr[1]), .mem_cs(mem_cs[1]), .mem_byte_sel(mem_byte_sel[1]), .mem_data(mem_data[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .busy(busy[1]), .done(done[1]));

    // Registered read on cs, combinational byte-lane select.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_cs[k]) ram_q[k] <= mem[mem_addr[k]];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ram
        assign mem_data[g] = mem_cs[g] ? (mem_byte_sel[g] ? ram_q[g][15:8] : ram_q[g][7:0]) : 8'h00;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor state
    bit   prv_reset = 1'b0, prv_valid = 1'b0, prv_ready = 1'b0, prv_cs = 1'b0, prv_done = 1'b0;
    bit   done_pend = 1'b0, done_exp = 1'b0, armed = 1'b0;
    bit   end_req = 1'b0, end_ack = 1'b0;
    int   lat = 0, wd = 0;
    exp_t e;
    logic [7:0] a_exp;

    always @(negedge clk) begin
        done_exp  = done_pend;
        done_pend = 1'b0;
        if (prv_reset) begin
            check("reset_outputs", 32'({out_valid[sel], busy[sel], done[sel], mem_cs[sel],
                                        mem_byte_sel[sel], mem_addr[sel], out_data[sel]}), 32'd0);
            armed = 1'b0;
        end else begin
            if (prv_valid && !prv_ready) check("valid_held", 32'(out_valid[sel]), 32'd1);
            if (out_valid[sel]) begin
                check("cs_low_in_emit", 32'(mem_cs[sel]), 32'd0);
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("out_data", 32'(out_data[sel]), 32'(exp_q[0].dat));
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        done_pend = e.last;
                    end
                end
            end
            if (mem_cs[sel] && !prv_cs) begin
                check("issue_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) begin
                    a_exp = addr_q.pop_front();
                    check("mem_addr", 32'(mem_addr[sel]), 32'(a_exp));
                end
            end
            if (done[sel] || done_exp) check("done", 32'(done[sel]), 32'(done_exp));
            if (prv_done) check("busy_after_done", 32'(busy[sel]), 32'd0);
            if (armed) begin
                lat++;
                if (lat == 1) check("busy_after_start", 32'(busy[sel]), 32'd1);
                if (out_valid[sel]) begin
                    check("first_valid_latency", 32'(lat), 32'd4);
                    armed = 1'b0;
                end
            end
        end
        if (start && !reset && !busy[sel]) begin
            armed = 1'b1;
            lat   = 0;
        end
        if ((exp_q.size() != 0 || busy[sel]) && !(out_valid[sel] && out_ready)) wd++;
        else wd = 0;
        if (wd > 200) begin
            check("progress_watchdog", 32'(wd), 32'd0);
            exp_q.delete();
            addr_q.delete();
            wd = 0;
        end
        if (end_req && !end_ack) begin
            check("bytes_drained", 32'(exp_q.size()), 32'd0);
            check("addrs_drained", 32'(addr_q.size()), 32'd0);
            end_ack = 1'b1;
        end
        prv_reset = reset;
        prv_valid = out_valid[sel];
        prv_ready = out_ready;
        prv_cs    = mem_cs[sel];
        prv_done  = done[sel];
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected bytes for one word on the selected instance; fin marks the run's last word.
    task automatic exp_word(input logic [7:0] a, input logic [15:0] w, input bit fin);
        exp_t x;
        addr_q.push_back(a);
        x.dat  = sel ? w[15:8] : w[7:0];
        x.last = 1'b0;
        exp_q.push_back(x);
        ck     = ck + x.dat;
        x.dat  = sel ? w[7:0] : w[15:8];
        x.last = fin && !CHK;
        exp_q.push_back(x);
        ck     = ck + x.dat;
        if (fin && CHK) begin
            x.dat  = ck;
            x.last = 1'b1;
            exp_q.push_back(x);
        end
        if (fin) ck = 8'h00;
    endtask

    task automatic go(input logic [7:0] sa, input logic [7:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
        start_addr = 8'hC3;
        end_addr   = 8'h3C;
    endtask

    task automatic wait_idle();
        int t = 0;
        cyc(1);
        while ((exp_q.size() != 0 || addr_q.size() != 0 || busy[sel]) && t < 3000) begin
            cyc(1);
            t++;
        end
        cyc(2);
    endtask

    initial begin
        int t;
        reset = 1'b1; start = 1'b0; start_addr = 8'h00; end_addr = 8'h00;
        rdy_man = 1'b1; rdy_mode = 1'b0; sel = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {~8'(i), 8'(i)};
        cyc(3);
        // start coinciding with reset must not launch a run
        start = 1'b1; start_addr = 8'h05; end_addr = 8'h05;
        cyc(1);
        reset = 1'b0; start = 1'b0;
        cyc(4);

        // single word, low byte first
        mem[0] = 16'h1234;
        exp_word(8'h00, 16'h1234, 1'b1);
        go(8'h00, 8'h00);
        wait_idle();

        // high byte first, four words
        sel = 1'b1;
        mem[0] = 16'hA1B2; mem[1] = 16'hC3D4; mem[2] = 16'hE5F6; mem[3] = 16'h0718;
        exp_word(8'h00, 16'hA1B2, 1'b0);
        exp_word(8'h01, 16'hC3D4, 1'b0);
        exp_word(8'h02, 16'hE5F6, 1'b0);
        exp_word(8'h03, 16'h0718, 1'b1);
        go(8'h00, 8'h03);
        wait_idle();
        sel = 1'b0;

        // wrap through 0xFF
        mem[8'hFE] = 16'h1122; mem[8'hFF] = 16'h3344; mem[8'h00] = 16'h5566; mem[8'h01] = 16'h7788;
        exp_word(8'hFE, 16'h1122, 1'b0);
        exp_word(8'hFF, 16'h3344, 1'b0);
        exp_word(8'h00, 16'h5566, 1'b0);
        exp_word(8'h01, 16'h7788, 1'b1);
        go(8'hFE, 8'h01);
        wait_idle();

        // random backpressure
        mem[8'h10] = 16'hCAFE; mem[8'h11] = 16'hBEEF; mem[8'h12] = 16'h9A0F;
        exp_word(8'h10, 16'hCAFE, 1'b0);
        exp_word(8'h11, 16'hBEEF, 1'b0);
        exp_word(8'h12, 16'h9A0F, 1'b1);
        rdy_mode = 1'b1;
        go(8'h10, 8'h12);
        wait_idle();
        rdy_mode = 1'b0;

        // start while busy is ignored
        mem[8'h20] = 16'h2468; mem[8'h21] = 16'h1357;
        exp_word(8'h20, 16'h2468, 1'b0);
        exp_word(8'h21, 16'h1357, 1'b1);
        go(8'h20, 8'h21);
        cyc(2);
        start_addr = 8'h80; end_addr = 8'h80; start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle();

        // reset while stalled on the second byte
        mem[8'h30] = 16'hABCD;
        exp_word(8'h30, 16'hABCD, 1'b0);
        ck = 8'h00;
        rdy_man = 1'b0;
        go(8'h30, 8'h30);
        t = 0;
        while (!out_valid[sel] && t < 50) begin
            cyc(1);
            t++;
        end
        rdy_man = 1'b1;
        cyc(1);
        rdy_man = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        exp_q.delete();
        addr_q.delete();
        reset = 1'b0;
        rdy_man = 1'b1;
        cyc(3);
        mem[0] = 16'h1234;
        exp_word(8'h00, 16'h1234, 1'b1);
        go(8'h00, 8'h00);
        wait_idle();

        // full 256-word sweep, end one below start
        for (int i = 0; i < 256; i++) mem[i] = {~8'(i), 8'(i)};
        for (int k = 0; k < 256; k++) exp_word(8'(8'h40 + k), mem[8'(8'h40 + k)], k == 255);
        go(8'h40, 8'h3F);
        wait_idle();

        end_req = 1'b1;
        t = 0;
        while (!end_ack && t < 20) begin
            cyc(1);
            t++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
